// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle RV32I control unit: state codes, opcodes,
// datapath select codes and the control-word bundle.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL_LINK  = 4'd9,
    S_JAL_PC    = 4'd10,
    S_AUIPC     = 4'd11,
    S_JALR      = 4'd12,
    S_EXEC_I    = 4'd13,
    S_HALT      = 4'd14,
    S_TRAP      = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_LINK   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/cu_output_decode.sv
// Combinational state-to-control-word decode; only FETCH looks at mem_ready.
// TRAP decode exists only when CU_ILLEGAL_TRAP_EN is defined.
module cu_output_decode
  import cu_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       fault_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Faulted upper state bits fall through to the all-zero default.
  always_comb begin
    ctrl_o           = '0;
    ctrl_o.pc_source = PCSRC_ALU;
    ctrl_o.alu_op    = ALUOP_ADD;
    ctrl_o.alu_src_b = SRCB_RS2;
    case ({fault_i, state_i})
      {1'b0, S_FETCH}: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.ir_write  = mem_ready_i;
      end
      {1'b0, S_DECODE}:   ctrl_o.alu_src_b = SRCB_IMM;
      {1'b0, S_MEM_ADDR}: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      {1'b0, S_MEM_READ}: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      {1'b0, S_MEM_WB}: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      {1'b0, S_MEM_WRITE}: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      {1'b0, S_EXEC_R}: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      {1'b0, S_R_WB}: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      {1'b0, S_BRANCH}: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_BRANCH;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      {1'b0, S_JAL_LINK}: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_source = PCSRC_LINK;
      end
      {1'b0, S_JAL_PC}: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      {1'b0, S_AUIPC}: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.reg_write = 1'b1;
      end
      {1'b0, S_JALR}: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.pc_write  = 1'b1;
      end
      {1'b0, S_EXEC_I}: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      {1'b0, S_HALT}: ctrl_o.halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
      {1'b0, S_TRAP}: ctrl_o.illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cu_fsm.sv
// Multicycle RV32I control unit: state register, next-state logic, instret counter.
// Define CU_ILLEGAL_TRAP_EN to send unknown opcodes to an absorbing TRAP state.
module multicycle_cu_fsm
  import cu_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   instret,
  output logic               halted,
  output logic               illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               fault_s;
  state_e             cur_s, nxt_s;
  ctrl_t              ctrl_s;

  // Any set bit above the 4-bit encoding is a corrupted state.
  generate
    if (STATE_W > 4) begin : g_hi_bits
      assign fault_s = |state_q[STATE_W-1:4];
    end else begin : g_no_hi_bits
      assign fault_s = 1'b0;
    end
  endgenerate

  assign cur_s = state_e'(state_q[3:0]);

  always_comb begin
    nxt_s = S_FETCH;
    case (cur_s)
      S_FETCH:  nxt_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: nxt_s = S_MEM_ADDR;
          OP_R:              nxt_s = S_EXEC_R;
          OP_I:              nxt_s = S_EXEC_I;
          OP_BRANCH:         nxt_s = S_BRANCH;
          OP_JAL, OP_JALR:   nxt_s = S_JAL_LINK;
          OP_AUIPC:          nxt_s = S_AUIPC;
          OP_SYSTEM:         nxt_s = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          default:           nxt_s = S_TRAP;
`else
          default:           nxt_s = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  nxt_s = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt_s = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    nxt_s = S_FETCH;
      S_MEM_WRITE: nxt_s = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    nxt_s = S_R_WB;
      S_R_WB:      nxt_s = S_FETCH;
      S_BRANCH:    nxt_s = S_FETCH;
      S_JAL_LINK:  nxt_s = (opcode == OP_JAL) ? S_JAL_PC : S_JALR;
      S_JAL_PC:    nxt_s = S_FETCH;
      S_AUIPC:     nxt_s = S_FETCH;
      S_JALR:      nxt_s = S_FETCH;
      S_EXEC_I:    nxt_s = S_R_WB;
      S_HALT:      nxt_s = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP:      nxt_s = S_TRAP;
`endif
      default:     nxt_s = S_FETCH;
    endcase

    state_d = fault_s ? STATE_W'(S_FETCH) : STATE_W'(nxt_s);

    // Retirement is any return to FETCH; HALT and TRAP never get here.
    if ((state_d == STATE_W'(S_FETCH)) && (state_q != STATE_W'(S_FETCH))) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_W'(S_FETCH);
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  cu_output_decode u_decode (
    .state_i     (state_q[3:0]),
    .fault_i     (fault_s),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  assign PCWrite     = ctrl_s.pc_write;
  assign PCWriteCond = ctrl_s.pc_write_cond;
  assign IorD        = ctrl_s.i_or_d;
  assign MemRead     = ctrl_s.mem_read;
  assign MemWrite    = ctrl_s.mem_write;
  assign IRWrite     = ctrl_s.ir_write;
  assign MemtoReg    = ctrl_s.mem_to_reg;
  assign ALUSrcA     = ctrl_s.alu_src_a;
  assign RegWrite    = ctrl_s.reg_write;
  assign RegDst      = ctrl_s.reg_dst;
  assign PCSource    = ctrl_s.pc_source;
  assign ALUOp       = ctrl_s.alu_op;
  assign ALUSrcB     = ctrl_s.alu_src_b;
  assign halted      = ctrl_s.halted;
  assign illegal     = ctrl_s.illegal;
  assign state       = state_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_cu_fsm.sv
// Bench for multicycle_cu_fsm: per-instruction state-path model checked every
// cycle, plus directed literal checks of the test-plan scenarios.
module tb_multicycle_cu_fsm;

  localparam int CW = 4;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] RTY   = 7'b0110011;
  localparam logic [6:0] ITY   = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] BAD   = 7'b1111111;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam int HALT_CNT = 1;
`else
  localparam int HALT_CNT = 12;
`endif

  logic clk, rst_n, mem_ready;
  logic [6:0] opcode;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic ALUSrcA, RegWrite, RegDst, halted, illegal;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic [CW-1:0] instret;
  logic [17:0] dut_ctrl;

  int n_chk = 0;
  int n_fail = 0;
  int m_pos = 0;
  logic [CW-1:0] m_cnt = '0;

  multicycle_cu_fsm #(.STATE_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .instret(instret), .halted(halted),
    .illegal(illegal)
  );

  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, halted, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full state path of one instruction, FETCH in the low nibble, 0 terminates.
  function automatic logic [23:0] path_of(input logic [6:0] op);
    case (op)
      LOAD:    path_of = 24'h043210;
      STORE:   path_of = 24'h005210;
      RTY:     path_of = 24'h007610;
      ITY:     path_of = 24'h007D10;
      BR:      path_of = 24'h000810;
      JAL:     path_of = 24'h00A910;
      JALR:    path_of = 24'h00C910;
      AUIPC:   path_of = 24'h000B10;
      SYS:     path_of = 24'h000E10;
`ifdef CU_ILLEGAL_TRAP_EN
      default: path_of = 24'h000F10;
`else
      default: path_of = 24'h000010;
`endif
    endcase
  endfunction

  function automatic logic [3:0] st_at(input logic [6:0] op, input int pos);
    logic [23:0] p;
    p = path_of(op);
    if (pos < 6) return p[4*pos +: 4];
    else return 4'd0;
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd, hl, il;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd, hl, il} = 12'd0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (s)
      4'd0:  begin mrd = 1'b1; srcb = 2'b01; pcw = mr; irw = mr; end
      4'd1:  srcb = 2'b10;
      4'd2:  begin srca = 1'b1; srcb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; end
      4'd6:  begin srca = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      4'd9:  begin rw = 1'b1; pcs = 2'b10; end
      4'd10: begin pcw = 1'b1; srcb = 2'b10; end
      4'd11: begin srcb = 2'b10; rw = 1'b1; end
      4'd12: begin srca = 1'b1; srcb = 2'b10; pcw = 1'b1; end
      4'd13: begin srca = 1'b1; srcb = 2'b10; aop = 2'b10; end
      4'd14: hl = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
      4'd15: il = 1'b1;
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rd, pcs, aop, srcb, hl, il};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: walk the instruction path; FETCH/MEM_READ/MEM_WRITE wait for mem_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_cnt <= '0;
    end else if (st_at(opcode, m_pos) inside {4'd14, 4'd15}) begin
      m_pos <= m_pos;
    end else if ((st_at(opcode, m_pos) inside {4'd0, 4'd3, 4'd5}) && !mem_ready) begin
      m_pos <= m_pos;
    end else if (st_at(opcode, m_pos + 1) != 4'd0) begin
      m_pos <= m_pos + 1;
    end else begin
      m_pos <= 0;
      m_cnt <= m_cnt + CW'(1);
    end
  end

  always @(negedge clk) begin
    chk("model_state", 32'(state), 32'(st_at(opcode, m_pos)));
    chk("model_instret", 32'(instret), 32'(m_cnt));
    chk("model_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(st_at(opcode, m_pos), mem_ready)));
  end

  logic [6:0] lat_op [8] = '{LOAD, STORE, RTY, ITY, BR, AUIPC, JAL, JALR};
  int lat_exp [8] = '{5, 4, 4, 4, 3, 3, 4, 4};

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = RTY;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_pcw_gated", 32'(PCWrite), 32'd0);
    chk("rst_irw_gated", 32'(IRWrite), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd1);
    mem_ready = 1'b1; #1;
    chk("rst_pcw_ready", 32'(PCWrite), 32'd1);
    chk("rst_irw_ready", 32'(IRWrite), 32'd1);
    step(); step();
    rst_n = 1'b1;

    step(); chk("r_s1", 32'(state), 32'd1);
    step(); chk("r_s6", 32'(state), 32'd6);
    step(); chk("r_s7", 32'(state), 32'd7);
    chk("r_regdst", 32'(RegDst), 32'd1);
    chk("r_regwrite", 32'(RegWrite), 32'd1);
    step(); chk("r_s0", 32'(state), 32'd0);
    chk("r_instret", 32'(instret), 32'd1);

    opcode = LOAD;
    step(); step(); chk("ld_s2", 32'(state), 32'd2);
    mem_ready = 1'b0;
    step(); chk("ld_s3a", 32'(state), 32'd3);
    chk("ld_memread", 32'(MemRead), 32'd1);
    chk("ld_iord", 32'(IorD), 32'd1);
    step(); chk("ld_s3b", 32'(state), 32'd3);
    step(); chk("ld_s3c", 32'(state), 32'd3);
    mem_ready = 1'b1;
    step(); chk("ld_s4", 32'(state), 32'd4);
    chk("ld_memtoreg", 32'(MemtoReg), 32'd1);
    step(); chk("ld_s0", 32'(state), 32'd0);
    chk("ld_instret", 32'(instret), 32'd2);

    mem_ready = 1'b0; opcode = JALR; #1;
    chk("fw_pcw0", 32'(PCWrite), 32'd0);
    chk("fw_irw0", 32'(IRWrite), 32'd0);
    step(); chk("fw_s0a", 32'(state), 32'd0);
    chk("fw_pcw1", 32'(PCWrite), 32'd0);
    step(); chk("fw_s0b", 32'(state), 32'd0);
    chk("fw_irw1", 32'(IRWrite), 32'd0);
    mem_ready = 1'b1; #1;
    chk("fw_pcw_go", 32'(PCWrite), 32'd1);
    chk("fw_irw_go", 32'(IRWrite), 32'd1);
    step(); chk("jalr_s1", 32'(state), 32'd1);
    chk("fw_pcw_once", 32'(PCWrite), 32'd0);
    chk("fw_irw_once", 32'(IRWrite), 32'd0);
    step(); chk("jalr_s9", 32'(state), 32'd9);
    chk("jalr_regwrite", 32'(RegWrite), 32'd1);
    step(); chk("jalr_s12", 32'(state), 32'd12);
    chk("jalr_pcw", 32'(PCWrite), 32'd1);
    chk("jalr_srca", 32'(ALUSrcA), 32'd1);
    step(); chk("jalr_s0", 32'(state), 32'd0);
    chk("jalr_instret", 32'(instret), 32'd3);

    for (int i = 0; i < 8; i++) begin
      int cyc;
      opcode = lat_op[i];
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (state != 4'd0 && cyc < 20);
      chk($sformatf("latency_%b", lat_op[i]), 32'(cyc), 32'(lat_exp[i]));
    end
    chk("lat_instret", 32'(instret), 32'd11);

    opcode = AUIPC;
    for (int k = 1; k <= 16; k++) begin
      step(); step(); step();
      if (k == 4) chk("wrap_15", 32'(instret), 32'd15);
      if (k == 5) chk("wrap_0", 32'(instret), 32'd0);
    end
    chk("wrap_16", 32'(instret), 32'd11);

    opcode = BAD;
    step(); chk("bad_s1", 32'(state), 32'd1);
    step();
`ifdef CU_ILLEGAL_TRAP_EN
    chk("bad_trap", 32'(state), 32'd15);
    chk("bad_illegal", 32'(illegal), 32'd1);
    chk("bad_instret", 32'(instret), 32'd11);
    step(); step();
    chk("trap_hold", 32'(state), 32'd15);
    chk("trap_instret", 32'(instret), 32'd11);
    rst_n = 1'b0; #1;
    chk("trap_rst", 32'(state), 32'd0);
    rst_n = 1'b1; opcode = AUIPC;
    step(); step(); step();
    chk("trap_after", 32'(instret), 32'd1);
`else
    chk("bad_fetch", 32'(state), 32'd0);
    chk("bad_illegal", 32'(illegal), 32'd0);
    chk("bad_instret", 32'(instret), 32'd12);
`endif

    opcode = SYS;
    step(); step();
    chk("halt_s14", 32'(state), 32'd14);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_instret", 32'(instret), 32'(HALT_CNT));
    end
    chk("halt_still", 32'(state), 32'd14);
    rst_n = 1'b0; #1;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_instret", 32'(instret), 32'd0);
    chk("halt_rst_flag", 32'(halted), 32'd0);

    step(); rst_n = 1'b1; opcode = STORE;
    step(); step(); chk("st_s2", 32'(state), 32'd2);
    mem_ready = 1'b0;
    step(); chk("st_s5", 32'(state), 32'd5);
    chk("st_memwrite", 32'(MemWrite), 32'd1);
    step(); chk("st_hold", 32'(state), 32'd5);
    rst_n = 1'b0; #1;
    chk("st_rst_state", 32'(state), 32'd0);
    chk("st_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("st_rst_instret", 32'(instret), 32'd0);
    mem_ready = 1'b1;
    step(); rst_n = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
